// File: rtl/excp_csr_trap_regs.sv
// Machine-mode trap CSR bank, fed directly by the exception commit logic.
// Holds mstatus (MIE/MPIE only), mepc, mcause, mtval, mtvec and mscratch.
// Services CSR-instruction reads and writes. Issues a registered one-cycle
// redirect to the trap vector or to mepc.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   cmt_*               trap / mret commit strobes and payload
//   csr_wr_en/idx/wdata CSR instruction write port (wdata already op-resolved)
//   csr_rdata/csr_ilgl  combinational read data / unimplemented-address flag
//   status_mie          mstatus.MIE, sent to the interrupt unit
//   redir_vld/redir_pc  registered one-cycle redirect to the IFU flush path
module excp_csr_trap_regs #(
    parameter int unsigned       XLEN      = 32,
    parameter int unsigned       PC_SIZE   = 32,
    parameter logic [XLEN-1:0]   MTVEC_RST = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmt_cause_ena,
    input  logic [XLEN-1:0]    cmt_cause,
    input  logic               cmt_badaddr_ena,
    input  logic [XLEN-1:0]    cmt_badaddr,
    input  logic               cmt_epc_ena,
    input  logic [PC_SIZE-1:0] cmt_epc,
    input  logic               cmt_status_ena,
    input  logic               cmt_mret_ena,
    input  logic               csr_wr_en,
    input  logic [11:0]        csr_idx,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               csr_ilgl,
    output logic               status_mie,
    output logic               redir_vld,
    output logic [PC_SIZE-1:0] redir_pc
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;

    logic               r_mie;
    logic               r_mpie;
    logic [PC_SIZE-1:0] r_mepc;
    logic [XLEN-1:0]    r_mcause;
    logic [XLEN-1:0]    r_mtval;
    logic [XLEN-1:0]    r_mtvec;
    logic [XLEN-1:0]    r_mscratch;
    logic               r_redir_vld;
    logic [PC_SIZE-1:0] r_redir_pc;

    logic [XLEN-1:0]    w_mstatus;
    logic [XLEN-1:0]    w_rdata;
    logic               w_ilgl;

    // mstatus view: MPP hardwired to machine mode, only MIE/MPIE stored.
    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mpie;
        w_mstatus[3]     = r_mie;
    end

    // Read mux over pre-update register values (no write bypass).
    always_comb begin
        w_rdata = '0;
        w_ilgl  = 1'b0;
        case (csr_idx)
            ADDR_MSTATUS:  w_rdata = w_mstatus;
            ADDR_MTVEC:    w_rdata = r_mtvec;
            ADDR_MSCRATCH: w_rdata = r_mscratch;
            ADDR_MEPC:     w_rdata = XLEN'(r_mepc);
            ADDR_MCAUSE:   w_rdata = r_mcause;
            ADDR_MTVAL:    w_rdata = r_mtval;
            default:       w_ilgl  = 1'b1;
        endcase
    end

    // Register update: trap > mret > CSR write > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie       <= 1'b0;
            r_mpie      <= 1'b0;
            r_mepc      <= '0;
            r_mcause    <= '0;
            r_mtval     <= '0;
            r_mtvec     <= MTVEC_RST & ~XLEN'(3);
            r_mscratch  <= '0;
            r_redir_vld <= 1'b0;
            r_redir_pc  <= '0;
        end else if (cmt_epc_ena) begin
            r_mepc <= cmt_epc & ~PC_SIZE'(1);
            if (cmt_cause_ena) begin
                r_mcause <= cmt_cause;
            end
            r_mtval <= cmt_badaddr_ena ? cmt_badaddr : '0;
            if (cmt_status_ena) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
            end
            r_redir_vld <= 1'b1;
            r_redir_pc  <= r_mtvec[PC_SIZE-1:0];
        end else if (cmt_mret_ena) begin
            r_mie       <= r_mpie;
            r_mpie      <= 1'b1;
            r_redir_vld <= 1'b1;
            r_redir_pc  <= r_mepc;
        end else begin
            r_redir_vld <= 1'b0;
            if (csr_wr_en && !w_ilgl) begin
                case (csr_idx)
                    ADDR_MSTATUS: begin
                        r_mie  <= csr_wdata[3];
                        r_mpie <= csr_wdata[7];
                    end
                    ADDR_MTVEC:    r_mtvec    <= csr_wdata & ~XLEN'(3);
                    ADDR_MSCRATCH: r_mscratch <= csr_wdata;
                    ADDR_MEPC:     r_mepc     <= csr_wdata[PC_SIZE-1:0] & ~PC_SIZE'(1);
                    ADDR_MCAUSE:   r_mcause   <= csr_wdata;
                    ADDR_MTVAL:    r_mtval    <= csr_wdata;
                    default:       ;
                endcase
            end
        end
    end

    assign csr_rdata  = w_rdata;
    assign csr_ilgl   = w_ilgl;
    assign status_mie = r_mie;
    assign redir_vld  = r_redir_vld;
    assign redir_pc   = r_redir_pc;

endmodule

// File: tb/tb_excp_csr_trap_regs.sv
// Scoreboard bench for excp_csr_trap_regs: stimulus pushes expected reads and
// redirects into queues; a negedge monitor pops and compares.
module tb_excp_csr_trap_regs;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PC_SIZE = 32;

    typedef struct {
        logic [11:0]     idx;
        logic [XLEN-1:0] rdata;
        logic            ilgl;
    } rd_exp_t;

    logic               clk;
    logic               rst;
    logic               cmt_cause_ena;
    logic [XLEN-1:0]    cmt_cause;
    logic               cmt_badaddr_ena;
    logic [XLEN-1:0]    cmt_badaddr;
    logic               cmt_epc_ena;
    logic [PC_SIZE-1:0] cmt_epc;
    logic               cmt_status_ena;
    logic               cmt_mret_ena;
    logic               csr_wr_en;
    logic [11:0]        csr_idx;
    logic [XLEN-1:0]    csr_wdata;
    logic [XLEN-1:0]    csr_rdata;
    logic               csr_ilgl;
    logic               status_mie;
    logic               redir_vld;
    logic [PC_SIZE-1:0] redir_pc;

    logic               rd_req;
    logic               done;
    rd_exp_t            q_rd[$];
    logic [PC_SIZE-1:0] q_redir[$];
    int                 n_chk;
    int                 n_fail;

    excp_csr_trap_regs #(
        .XLEN      (XLEN),
        .PC_SIZE   (PC_SIZE),
        .MTVEC_RST (32'h0000_0103)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmt_cause_ena   (cmt_cause_ena),
        .cmt_cause       (cmt_cause),
        .cmt_badaddr_ena (cmt_badaddr_ena),
        .cmt_badaddr     (cmt_badaddr),
        .cmt_epc_ena     (cmt_epc_ena),
        .cmt_epc         (cmt_epc),
        .cmt_status_ena  (cmt_status_ena),
        .cmt_mret_ena    (cmt_mret_ena),
        .csr_wr_en       (csr_wr_en),
        .csr_idx         (csr_idx),
        .csr_wdata       (csr_wdata),
        .csr_rdata       (csr_rdata),
        .csr_ilgl        (csr_ilgl),
        .status_mie      (status_mie),
        .redir_vld       (redir_vld),
        .redir_pc        (redir_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and drop all single-cycle strobes.
    task automatic cyc();
        @(posedge clk);
        #1;
        cmt_cause_ena   = 1'b0;
        cmt_badaddr_ena = 1'b0;
        cmt_epc_ena     = 1'b0;
        cmt_status_ena  = 1'b0;
        cmt_mret_ena    = 1'b0;
        csr_wr_en       = 1'b0;
        rd_req          = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] idx, input logic [XLEN-1:0] d);
        csr_idx   = idx;
        csr_wdata = d;
        csr_wr_en = 1'b1;
        cyc();
    endtask

    task automatic exp_read(input logic [11:0] idx, input logic [XLEN-1:0] d, input logic ilgl);
        rd_exp_t e;
        e.idx   = idx;
        e.rdata = d;
        e.ilgl  = ilgl;
        csr_idx = idx;
        rd_req  = 1'b1;
        q_rd.push_back(e);
        cyc();
    endtask

    // Drive one trap commit; the caller decides whether to advance the clock.
    task automatic set_trap(input logic [PC_SIZE-1:0] epc, input logic [XLEN-1:0] cause,
                            input logic [XLEN-1:0] bad, input logic bad_ena);
        cmt_epc_ena     = 1'b1;
        cmt_epc         = epc;
        cmt_cause_ena   = 1'b1;
        cmt_cause       = cause;
        cmt_badaddr_ena = bad_ena;
        cmt_badaddr     = bad;
        cmt_status_ena  = 1'b1;
    endtask

    // Monitor: compares reads and redirects against the expectation queues.
    always @(negedge clk) begin
        if (rd_req) begin
            rd_exp_t e;
            n_chk = n_chk + 1;
            if (q_rd.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL rd_queue: read strobe with no expectation");
            end else begin
                e = q_rd.pop_front();
                if (csr_rdata !== e.rdata || csr_ilgl !== e.ilgl) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rd_%03h: got rdata=%08h ilgl=%0b, want rdata=%08h ilgl=%0b",
                             e.idx, csr_rdata, csr_ilgl, e.rdata, e.ilgl);
                end
            end
        end
        if (redir_vld !== 1'b0) begin
            n_chk = n_chk + 1;
            if (q_redir.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL redir_spurious: redir_vld=%0b pc=%08h, want no redirect",
                         redir_vld, redir_pc);
            end else begin
                logic [PC_SIZE-1:0] exp_pc;
                exp_pc = q_redir.pop_front();
                if (redir_pc !== exp_pc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL redir_pc: got %08h, want %08h", redir_pc, exp_pc);
                end
            end
        end
        if (done) begin
            n_chk = n_chk + 1;
            if (q_redir.size() != 0) begin
                n_fail = n_fail + 1;
                $display("FAIL redir_missing: %0d redirects outstanding, want 0", q_redir.size());
            end
            n_chk = n_chk + 1;
            if (q_rd.size() != 0) begin
                n_fail = n_fail + 1;
                $display("FAIL rd_missing: %0d reads outstanding, want 0", q_rd.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin
        n_chk           = 0;
        n_fail          = 0;
        done            = 1'b0;
        rd_req          = 1'b0;
        rst             = 1'b1;
        cmt_cause_ena   = 1'b0;
        cmt_cause       = '0;
        cmt_badaddr_ena = 1'b0;
        cmt_badaddr     = '0;
        cmt_epc_ena     = 1'b0;
        cmt_epc         = '0;
        cmt_status_ena  = 1'b0;
        cmt_mret_ena    = 1'b0;
        csr_wr_en       = 1'b0;
        csr_idx         = '0;
        csr_wdata       = '0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset values; mtvec low bits masked off.
        exp_read(12'h300, 32'h0000_1800, 1'b0);
        exp_read(12'h305, 32'h0000_0100, 1'b0);
        exp_read(12'h340, 32'h0, 1'b0);
        exp_read(12'h341, 32'h0, 1'b0);
        exp_read(12'h342, 32'h0, 1'b0);
        exp_read(12'h343, 32'h0, 1'b0);

        // mstatus masking, and read-during-write returns the old value.
        csr_write(12'h300, 32'h0000_0008);
        exp_read(12'h300, 32'h0000_1808, 1'b0);
        csr_idx   = 12'h300;
        csr_wdata = 32'hFFFF_FFF7;
        csr_wr_en = 1'b1;
        exp_read(12'h300, 32'h0000_1808, 1'b0);
        exp_read(12'h300, 32'h0000_1880, 1'b0);
        csr_write(12'h300, 32'h0000_0008);
        csr_write(12'h305, 32'h0000_0080);
        exp_read(12'h305, 32'h0000_0080, 1'b0);

        // Trap: redirect to old mtvec, MIE stacked.
        set_trap(32'h0000_1003, 32'h0000_000B, 32'h0000_0055, 1'b1);
        q_redir.push_back(32'h0000_0080);
        cyc();
        exp_read(12'h341, 32'h0000_1002, 1'b0);
        exp_read(12'h342, 32'h0000_000B, 1'b0);
        exp_read(12'h343, 32'h0000_0055, 1'b0);
        exp_read(12'h300, 32'h0000_1880, 1'b0);

        // mret: redirect to mepc, MIE restored.
        cmt_mret_ena = 1'b1;
        q_redir.push_back(32'h0000_1002);
        cyc();
        exp_read(12'h300, 32'h0000_1888, 1'b0);

        // Back-to-back trap (badaddr off) then mret.
        set_trap(32'h0000_2000, 32'h8000_0007, 32'h0000_0077, 1'b0);
        q_redir.push_back(32'h0000_0080);
        cyc();
        cmt_mret_ena = 1'b1;
        q_redir.push_back(32'h0000_2000);
        cyc();
        exp_read(12'h343, 32'h0, 1'b0);
        exp_read(12'h342, 32'h8000_0007, 1'b0);
        exp_read(12'h341, 32'h0000_2000, 1'b0);
        exp_read(12'h300, 32'h0000_1888, 1'b0);

        // Collision: trap + mret + CSR write; only the trap takes effect.
        set_trap(32'h0000_3004, 32'h0000_0002, 32'h0000_0011, 1'b1);
        cmt_mret_ena = 1'b1;
        csr_idx      = 12'h340;
        csr_wdata    = 32'h0000_00AA;
        csr_wr_en    = 1'b1;
        q_redir.push_back(32'h0000_0080);
        cyc();
        exp_read(12'h340, 32'h0, 1'b0);
        exp_read(12'h341, 32'h0000_3004, 1'b0);
        exp_read(12'h343, 32'h0000_0011, 1'b0);
        exp_read(12'h300, 32'h0000_1880, 1'b0);

        // Field enables without epc enable are ignored.
        cmt_cause_ena   = 1'b1;
        cmt_cause       = 32'h0000_0005;
        cmt_badaddr_ena = 1'b1;
        cmt_badaddr     = 32'h0000_0099;
        cmt_status_ena  = 1'b1;
        cyc();
        exp_read(12'h342, 32'h0000_0002, 1'b0);
        exp_read(12'h343, 32'h0000_0011, 1'b0);
        exp_read(12'h300, 32'h0000_1880, 1'b0);

        // Plain CSR accesses with masking, and an unimplemented address.
        csr_write(12'h305, 32'h0000_0203);
        exp_read(12'h305, 32'h0000_0200, 1'b0);
        csr_write(12'h341, 32'h0000_4567);
        exp_read(12'h341, 32'h0000_4566, 1'b0);
        csr_write(12'h340, 32'hDEAD_BEEF);
        exp_read(12'h340, 32'hDEAD_BEEF, 1'b0);
        csr_write(12'h7C0, 32'h1234_5678);
        exp_read(12'h7C0, 32'h0, 1'b1);
        exp_read(12'h340, 32'hDEAD_BEEF, 1'b0);

        // Trap then reset (with an mret that must be ignored); redirect must stop.
        set_trap(32'h0000_5000, 32'h0000_0003, 32'h0, 1'b0);
        q_redir.push_back(32'h0000_0200);
        cyc();
        rst          = 1'b1;
        cmt_mret_ena = 1'b1;
        cyc();
        rst = 1'b0;
        exp_read(12'h341, 32'h0, 1'b0);
        exp_read(12'h300, 32'h0000_1800, 1'b0);
        exp_read(12'h305, 32'h0000_0100, 1'b0);
        cyc();
        cyc();
        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL timeout: monitor did not finish");
        $fatal(1);
    end

endmodule
